rep_sequencer: RTL and testbench

- Controller that sequences REP/REPE/REPNE string-instruction iterations for the microcode engine.
- Owns the iteration counter loaded from CX and issues one iteration request at a time to the string datapath.
- Terminates the loop on count exhaustion or ZF mismatch, and writes back the decremented CX.
- Yields to pending interrupts between iterations so the instruction can restart from the prefix.

---
 rtl/rep_sequencer.sv | 108 ++++++++++
 tb/tb_rep_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rep_sequencer.sv
// REP/REPE/REPNE iteration sequencer for the microcode string engine.
// Issues one datapath iteration at a time and writes back the decremented CX.
module rep_sequencer #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [1:0]             rep_mode,
    input  logic                   is_compare,
    input  logic [COUNT_WIDTH-1:0] cx_in,
    output logic                   iter_req,
    input  logic                   iter_ack,
    input  logic                   iter_done,
    input  logic                   zf_in,
    input  logic                   irq_pending,
    output logic [COUNT_WIDTH-1:0] cx_out,
    output logic                   cx_wr_en,
    output logic                   busy,
    output logic                   complete,
    output logic                   interrupted
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ISSUE,
        WAIT,
        DONE,
        SUSPEND
    } state_t;

    localparam logic [1:0] M_NONE  = 2'b00;
    localparam logic [1:0] M_REPE  = 2'b10;
    localparam logic [1:0] M_REPNE = 2'b11;

    state_t                 state;
    logic [1:0]             mode;
    logic                   cmp;
    logic                   first;
    logic [COUNT_WIDTH-1:0] count;
    logic                   zf_stop;

    assign zf_stop = cmp && (((mode == M_REPE) && !zf_in) ||
                             ((mode == M_REPNE) && zf_in));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            mode     <= M_NONE;
            cmp      <= 1'b0;
            first    <= 1'b0;
            count    <= '0;
            cx_out   <= '0;
            cx_wr_en <= 1'b0;
        end else begin
            cx_wr_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode  <= rep_mode;
                        cmp   <= is_compare;
                        count <= cx_in;
                        first <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    // interrupts only break in once an iteration has completed
                    if ((mode != M_NONE) && (count == '0))
                        state <= DONE;
                    else if (irq_pending && !first)
                        state <= SUSPEND;
                    else
                        state <= ISSUE;
                end
                ISSUE: begin
                    if (iter_ack) begin
                        first <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (iter_done) begin
                        if (mode != M_NONE) begin
                            count    <= count - 1'b1;
                            cx_out   <= count - 1'b1;
                            cx_wr_en <= 1'b1;
                        end
                        if ((mode == M_NONE) || zf_stop)
                            state <= DONE;
                        else
                            state <= CHECK;
                    end
                end
                DONE:    state <= IDLE;
                SUSPEND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign iter_req    = (state == ISSUE);
    assign busy        = (state != IDLE);
    assign complete    = (state == DONE);
    assign interrupted = (state == SUSPEND);

endmodule

// File: tb/tb_rep_sequencer.sv
// Randomized bench for rep_sequencer: bench emulates the string datapath
// and compares against a transaction-level loop model.
module tb_rep_sequencer;

    localparam int W = 16;
    localparam int NEVER = 1000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   rep_mode = 2'b00;
    logic         is_compare = 1'b0;
    logic [W-1:0] cx_in = '0;
    logic         iter_req;
    logic         iter_ack = 1'b0;
    logic         iter_done = 1'b0;
    logic         zf_in = 1'b0;
    logic         irq_pending = 1'b0;
    logic [W-1:0] cx_out;
    logic         cx_wr_en;
    logic         busy;
    logic         complete;
    logic         interrupted;

    rep_sequencer #(.COUNT_WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .rep_mode    (rep_mode),
        .is_compare  (is_compare),
        .cx_in       (cx_in),
        .iter_req    (iter_req),
        .iter_ack    (iter_ack),
        .iter_done   (iter_done),
        .zf_in       (zf_in),
        .irq_pending (irq_pending),
        .cx_out      (cx_out),
        .cx_wr_en    (cx_wr_en),
        .busy        (busy),
        .complete    (complete),
        .interrupted (interrupted)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // expected outcome of one instruction
    int           exp_iters;
    bit           exp_cmpl;
    bit           exp_by_iter;
    logic [W-1:0] exp_wr[$];

    function automatic void model(input logic [1:0] m, input bit c,
                                  input int cx, input int irq_from,
                                  input logic [31:0] zf);
        int cnt;
        bit z;
        cnt = cx;
        exp_iters = 0;
        exp_wr.delete();
        while (1) begin
            if (m != 2'b00 && cnt == 0) begin
                exp_cmpl = 1; exp_by_iter = 0; return;
            end
            if (exp_iters > 0 && irq_from <= exp_iters) begin
                exp_cmpl = 0; exp_by_iter = 0; return;
            end
            exp_iters++;
            z = zf[exp_iters-1];
            if (m != 2'b00) begin
                cnt = cnt - 1;
                exp_wr.push_back(W'(cnt));
            end
            if (m == 2'b00 || (c && m == 2'b10 && !z) ||
                (c && m == 2'b11 && z)) begin
                exp_cmpl = 1; exp_by_iter = 1; return;
            end
        end
    endfunction

    task automatic run(input logic [1:0] m, input bit c, input int cx,
                       input int irq_from, input logic [31:0] zf,
                       input int dly, input bit poke);
        int cyc, d, gap, wc, iters, reqc, last_done, first_req, ds;
        bit ended, gotc, goti;
        logic [W-1:0] got_wr[$];
        model(m, c, cx, irq_from, zf);
        @(negedge clk);
        start = 1'b1;
        rep_mode = m;
        is_compare = c;
        cx_in = W'(cx);
        irq_pending = (irq_from == 0);
        cyc = 0; ds = 0; wc = 0; iters = 0; reqc = 0; gap = 0;
        last_done = -100; first_req = -1;
        ended = 0; gotc = 0; goti = 0;
        d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
        while (!ended && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            iter_done = 1'b0;
            if (cx_wr_en) begin
                chk("wr_lat", cyc - last_done, 1);
                got_wr.push_back(cx_out);
            end
            if (complete || interrupted) begin
                ended = 1;
                gotc = complete;
                goti = interrupted;
                if (exp_iters > 0)
                    chk("end_lat", cyc - last_done, exp_by_iter ? 1 : 2);
                else
                    chk("zero_lat", cyc, 2);
            end else begin
                case (ds)
                    0: if (iter_req) begin
                        if (first_req < 0) first_req = cyc;
                        reqc++;
                        if (wc == d) begin
                            iter_ack = 1'b1;
                            ds = 1;
                        end else wc++;
                    end
                    1: begin
                        iter_ack = 1'b0;
                        iters++;
                        chk("req_hold", reqc, d + 1);
                        chk("req_drop", iter_req, 0);
                        gap = $urandom_range(0, 3);
                        ds = 2;
                    end
                    default: if (gap == 0) begin
                        iter_done = 1'b1;
                        zf_in = zf[(iters - 1) % 32];
                        last_done = cyc;
                        if (irq_from == iters) irq_pending = 1'b1;
                        ds = 0; wc = 0; reqc = 0;
                        d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
                    end else gap--;
                endcase
                if (poke && cyc == 4 && busy) begin
                    start = 1'b1;
                    cx_in = '1;
                    rep_mode = 2'b01;
                end
            end
        end
        if (!ended) chk("timeout", 0, 1);
        chk("iters", iters, exp_iters);
        chk("complete", gotc, exp_cmpl);
        chk("interrupted", goti, !exp_cmpl);
        chk("nwr", got_wr.size(), exp_wr.size());
        for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
            chk("cx_out", got_wr[i], exp_wr[i]);
        if (exp_iters > 0) chk("first_req", first_req, 2);
        irq_pending = 1'b0;
        iter_ack = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("one_pulse", {complete, interrupted}, 0);
    endtask

    initial begin
        int lim;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {iter_req, cx_wr_en, complete, interrupted, busy,
                         cx_out}, 0);
        reset_n = 1'b1;

        run(2'b01, 0, 3, NEVER, 32'h0, -1, 0);
        run(2'b01, 0, 0, NEVER, 32'h0, -1, 0);
        run(2'b10, 1, 5, NEVER, 32'b011, -1, 0);
        run(2'b11, 1, 5, NEVER, 32'b10, -1, 0);
        run(2'b01, 0, 4, 2, 32'h0, -1, 0);
        run(2'b01, 0, 4, 0, 32'h0, -1, 0);
        run(2'b00, 0, 0, NEVER, 32'h0, 3, 0);
        run(2'b10, 0, 3, NEVER, 32'h0, 0, 1);
        run(2'b01, 0, 1, 1, 32'h0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            logic [1:0] m;
            int irqf;
            m = 2'($urandom_range(0, 3));
            irqf = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(0, 4)) : NEVER;
            run(m, 1'($urandom_range(0, 1)), int'($urandom_range(0, 8)),
                irqf, $urandom, -1, 1'($urandom_range(0, 1)));
        end

        // reset while an iteration is in flight
        @(negedge clk);
        start = 1'b1; rep_mode = 2'b01; is_compare = 1'b0; cx_in = 16'd7;
        @(negedge clk);
        start = 1'b0;
        lim = 0;
        while (!iter_req && lim < 10) begin
            @(negedge clk);
            lim++;
        end
        chk("rst_req_seen", iter_req, 1);
        iter_ack = 1'b1;
        @(negedge clk);
        iter_ack = 1'b0;
        chk("rst_in_wait", {busy, iter_req}, 2'b10);
        #2 reset_n = 1'b0;
        #1 chk("rst_async", {iter_req, cx_wr_en, complete, interrupted,
                             busy, cx_out}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        iter_done = 1'b1;
        @(negedge clk);
        iter_done = 1'b0;
        chk("rst_stale", {cx_wr_en, busy, complete}, 0);
        run(2'b01, 0, 2, NEVER, 32'h0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
